// File: rtl/clause_operand_fetcher.sv
// Fetches one clause, gathers each slot's assignment status into evaluator-ready vectors.
// Clause word = {var ids, pole, mask}; mask in the low VAR_PER_CLAUSE bits. Option: GATHER_WRITE_BYPASS_EN.
module clause_operand_fetcher #(
  parameter int VAR_PER_CLAUSE = 5,
  parameter int NUM_VARS       = 64,
  parameter int NUM_CLAUSES    = 32,
  parameter int VAR_IDX_W      = $clog2(NUM_VARS),
  parameter int CL_IDX_W       = $clog2(NUM_CLAUSES)
) (
  input  logic                                                 clock,
  input  logic                                                 reset_n,
  input  logic                                                 req_valid,
  input  logic [CL_IDX_W-1:0]                                  req_clause,
  output logic                                                 req_ready,
  output logic                                                 clause_rd_en,
  output logic [CL_IDX_W-1:0]                                  clause_rd_addr,
  input  logic [VAR_PER_CLAUSE*VAR_IDX_W+2*VAR_PER_CLAUSE-1:0] clause_rd_data,
  input  logic                                                 asgn_wr_en,
  input  logic [VAR_IDX_W-1:0]                                 asgn_wr_var,
  input  logic                                                 asgn_wr_assigned,
  input  logic                                                 asgn_wr_val,
  input  logic                                                 asgn_clear,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic [CL_IDX_W-1:0]                                  out_clause,
  output logic [VAR_PER_CLAUSE-1:0]                            unassign,
  output logic [VAR_PER_CLAUSE-1:0]                            clause_mask,
  output logic [VAR_PER_CLAUSE-1:0]                            val,
  output logic [VAR_PER_CLAUSE-1:0]                            clause_pole
);

  localparam int CNT_W = (VAR_PER_CLAUSE > 1) ? $clog2(VAR_PER_CLAUSE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(VAR_PER_CLAUSE - 1);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, GATHER, PRESENT} state_t;

  state_t               state, state_next;
  logic [NUM_VARS-1:0]  tbl_assigned, tbl_value;
  logic [VAR_IDX_W-1:0] slot_id [VAR_PER_CLAUSE];
  logic [CNT_W-1:0]     slot_cnt;
  logic [VAR_IDX_W-1:0] cur_id;
  logic                 cur_assigned, cur_value;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    clause_rd_en = 1'b0;
    out_valid    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          clause_rd_en = 1'b1;
          state_next   = MEM_WAIT;
        end
      end
      MEM_WAIT: state_next = GATHER;
      GATHER:   if (slot_cnt == LAST_SLOT) state_next = PRESENT;
      PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign clause_rd_addr = req_clause;

  // Clear wins over a simultaneous write; value bits are don't-care once unassigned.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tbl_assigned <= '0;
      tbl_value    <= '0;
    end else if (asgn_clear) begin
      tbl_assigned <= '0;
    end else if (asgn_wr_en) begin
      tbl_assigned[asgn_wr_var] <= asgn_wr_assigned;
      tbl_value[asgn_wr_var]    <= asgn_wr_val;
    end
  end

  always_comb begin
    cur_id       = slot_id[slot_cnt];
    cur_assigned = tbl_assigned[cur_id];
    cur_value    = tbl_value[cur_id];
`ifdef GATHER_WRITE_BYPASS_EN
    if (asgn_clear) begin
      cur_assigned = 1'b0;
    end else if (asgn_wr_en && (asgn_wr_var == cur_id)) begin
      cur_assigned = asgn_wr_assigned;
      cur_value    = asgn_wr_val;
    end
`endif
  end

  // Each slot is captured once, so later table writes never disturb the presented snapshot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_clause  <= '0;
      clause_mask <= '0;
      clause_pole <= '0;
      unassign    <= '0;
      val         <= '0;
      slot_cnt    <= '0;
      for (int i = 0; i < VAR_PER_CLAUSE; i++) slot_id[i] <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) out_clause <= req_clause;
        MEM_WAIT: begin
          clause_mask <= clause_rd_data[VAR_PER_CLAUSE-1:0];
          clause_pole <= clause_rd_data[2*VAR_PER_CLAUSE-1:VAR_PER_CLAUSE];
          for (int i = 0; i < VAR_PER_CLAUSE; i++)
            slot_id[i] <= clause_rd_data[2*VAR_PER_CLAUSE + i*VAR_IDX_W +: VAR_IDX_W];
          slot_cnt <= '0;
        end
        GATHER: begin
          unassign[slot_cnt] <= clause_mask[slot_cnt] & ~cur_assigned;
          val[slot_cnt]      <= clause_mask[slot_cnt] & cur_assigned & cur_value;
          if (slot_cnt != LAST_SLOT) slot_cnt <= slot_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clause_operand_fetcher.sv
// Self-checking bench for clause_operand_fetcher: directed vector table, corner sequences,
// and randomized fetches with concurrent table writes against a behavioural table model.
module tb_clause_operand_fetcher;

  localparam int VPC = 5;
  localparam int NV  = 64;
  localparam int NC  = 32;
  localparam int VW  = 6;
  localparam int CW  = 5;
  localparam int DW  = VPC*VW + 2*VPC;

  typedef struct {
    int                     cl;
    logic [VPC-1:0][VW-1:0] ids;
    logic [VPC-1:0]         mask;
    logic [VPC-1:0]         pole;
    logic [VPC-1:0]         exp_unassign;
    logic [VPC-1:0]         exp_val;
  } vec_t;

  logic           clock, reset_n;
  logic           req_valid, req_ready, clause_rd_en;
  logic [CW-1:0]  req_clause, clause_rd_addr, out_clause;
  logic [DW-1:0]  clause_rd_data;
  logic           asgn_wr_en, asgn_wr_assigned, asgn_wr_val, asgn_clear;
  logic [VW-1:0]  asgn_wr_var;
  logic           out_valid, out_ready;
  logic [VPC-1:0] unassign, clause_mask, val, clause_pole;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] clause_mem [NC];
  bit m_asg [NV];
  bit m_val [NV];
  bit w_clear, w_en, w_asg, w_val;
  int w_var;
  vec_t vecs [4];

  clause_operand_fetcher dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_clause(req_clause), .req_ready(req_ready),
    .clause_rd_en(clause_rd_en), .clause_rd_addr(clause_rd_addr), .clause_rd_data(clause_rd_data),
    .asgn_wr_en(asgn_wr_en), .asgn_wr_var(asgn_wr_var), .asgn_wr_assigned(asgn_wr_assigned),
    .asgn_wr_val(asgn_wr_val), .asgn_clear(asgn_clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_clause(out_clause),
    .unassign(unassign), .clause_mask(clause_mask), .val(val), .clause_pole(clause_pole)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Clause memory: registered read, data valid the cycle after the strobe.
  always @(posedge clock) if (clause_rd_en) clause_rd_data <= clause_mem[clause_rd_addr];

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_write(input bit c, input bit e, input int v, input bit a, input bit x);
    w_clear = c; w_en = e; w_var = v; w_asg = a; w_val = x;
    asgn_clear = c; asgn_wr_en = e; asgn_wr_var = VW'(v);
    asgn_wr_assigned = a; asgn_wr_val = x;
  endtask

  task automatic apply_stimulus_random_write();
    int r;
    int v;
    r = $urandom_range(0, 19);
    v = ($urandom_range(0, 9) == 0) ? 63 : $urandom_range(0, 15);
    if (r == 0)      drive_write(1'b1, $urandom_range(0, 1), v, 1'b1, 1'b1);
    else if (r < 9)  drive_write(1'b0, 1'b1, v, $urandom_range(0, 1), $urandom_range(0, 1));
    else             drive_write(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // What the slot being gathered this cycle sees of variable v.
  task automatic gather_view(input int v, output bit a, output bit x);
    a = m_asg[v];
    x = m_val[v];
`ifdef GATHER_WRITE_BYPASS_EN
    if (w_clear) a = 1'b0;
    else if (w_en && w_var == v) begin a = w_asg; x = w_val; end
`endif
  endtask

  task automatic commit_write();
    if (w_clear) begin
      for (int i = 0; i < NV; i++) m_asg[i] = 1'b0;
    end else if (w_en) begin
      m_asg[w_var] = w_asg;
      m_val[w_var] = w_val;
    end
  endtask

  task automatic step();
    commit_write();
    @(posedge clock);
    #1;
  endtask

  // One full fetch/present/handshake; f_cyc selects a cycle (0 = accept) with a forced write.
  task automatic run_fetch(input int cl, input bit rnd, input int stall,
                           input int f_cyc, input bit f_clear, input bit f_en, input int f_var,
                           input bit f_asg, input bit f_val,
                           output logic [VPC-1:0] got_u, output logic [VPC-1:0] got_v);
    logic [DW-1:0]          word;
    logic [VPC-1:0]         m_mask;
    logic [VPC-1:0][VW-1:0] m_ids;
    logic [VPC-1:0]         exp_u, exp_v;
    bit a, x;
    word   = clause_mem[cl];
    m_mask = word[VPC-1:0];
    m_ids  = word[DW-1:2*VPC];
    exp_u  = '0;
    exp_v  = '0;
    check_output("req_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_clause = CW'(cl);
    for (int c = 0; c < VPC + 2; c++) begin
      if (c == f_cyc)   drive_write(f_clear, f_en, f_var, f_asg, f_val);
      else if (rnd)     apply_stimulus_random_write();
      else              drive_write(1'b0, 1'b0, 0, 1'b0, 1'b0);
      if (c >= 2) begin
        gather_view(m_ids[c-2], a, x);
        exp_u[c-2] = m_mask[c-2] & ~a;
        exp_v[c-2] = m_mask[c-2] & a & x;
      end
      #1;
      if (c == 0) begin
        check_output("rd_en_pulse", clause_rd_en, 1);
        check_output("rd_addr", clause_rd_addr, cl);
      end
      step();
      if (c == 0) req_valid = 1'b0;
      else if (rnd) begin
        req_valid  = $urandom_range(0, 1);
        req_clause = CW'($urandom_range(0, NC-1));
      end
      if (c == VPC) check_output("out_valid_early", out_valid, 0);
    end
    check_output("out_valid_latency", out_valid, 1);
    check_output("out_clause", out_clause, cl);
    check_output("clause_mask", clause_mask, m_mask);
    check_output("clause_pole", clause_pole, word[2*VPC-1:VPC]);
    check_output("unassign_model", unassign, exp_u);
    check_output("val_model", val, exp_v);
    got_u = unassign;
    got_v = val;
    for (int k = 0; k < stall; k++) begin
      out_ready  = 1'b0;
      req_valid  = 1'b1;
      req_clause = CW'($urandom_range(0, NC-1));
      if (rnd) apply_stimulus_random_write();
      else     drive_write(1'b0, 1'b1, m_ids[k % VPC], ~m_asg[m_ids[k % VPC]], 1'b1);
      #1;
      check_output("rd_en_ignored", clause_rd_en, 0);
      step();
      check_output("stall_valid", out_valid, 1);
      check_output("stall_unassign", unassign, exp_u);
      check_output("stall_val", val, exp_v);
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    if (rnd) apply_stimulus_random_write();
    else     drive_write(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step();
    out_ready = 1'b0;
    check_output("handshake_valid", out_valid, 0);
    check_output("handshake_ready", req_ready, 1);
  endtask

  initial begin
    logic [VPC-1:0] gu, gv;
    logic [VPC-1:0] e_u, e_v;

    reset_n = 1'b0; req_valid = 1'b0; req_clause = '0; out_ready = 1'b0;
    clause_rd_data = '0;
    drive_write(1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < NV; i++) begin m_asg[i] = 1'b0; m_val[i] = 1'b0; end

    vecs[0].cl = 4;  vecs[0].ids = {6'd0, 6'd0, 6'd9, 6'd7, 6'd3};
    vecs[0].mask = 5'b00111; vecs[0].pole = 5'b00011;
    vecs[0].exp_unassign = 5'b00100; vecs[0].exp_val = 5'b00001;
    vecs[1].cl = 10; vecs[1].ids = {6'd7, 6'd5, 6'd3, 6'd12, 6'd12};
    vecs[1].mask = 5'b11111; vecs[1].pole = 5'b10101;
    vecs[1].exp_unassign = 5'b01000; vecs[1].exp_val = 5'b00111;
    vecs[2].cl = 0;  vecs[2].ids = {6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
    vecs[2].mask = 5'b00000; vecs[2].pole = 5'b00000;
    vecs[2].exp_unassign = 5'b00000; vecs[2].exp_val = 5'b00000;
    vecs[3].cl = 31; vecs[3].ids = {6'd12, 6'd3, 6'd63, 6'd9, 6'd7};
    vecs[3].mask = 5'b11010; vecs[3].pole = 5'b11111;
    vecs[3].exp_unassign = 5'b00010; vecs[3].exp_val = 5'b11000;

    for (int i = 0; i < NC; i++) begin
      logic [VPC-1:0][VW-1:0] rid;
      for (int s = 0; s < VPC; s++)
        rid[s] = ($urandom_range(0, 7) == 0) ? 6'd63 : VW'($urandom_range(0, 15));
      clause_mem[i] = {rid, VPC'($urandom), VPC'($urandom)};
    end
    foreach (vecs[i]) clause_mem[vecs[i].cl] = {vecs[i].ids, vecs[i].pole, vecs[i].mask};

    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_output("rst_req_ready", req_ready, 1);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_rd_en", clause_rd_en, 0);
    check_output("rst_out_clause", out_clause, 0);
    check_output("rst_unassign", unassign, 0);
    check_output("rst_clause_mask", clause_mask, 0);
    check_output("rst_val", val, 0);
    check_output("rst_clause_pole", clause_pole, 0);

    drive_write(1'b0, 1'b1, 3, 1'b1, 1'b1);  step();
    drive_write(1'b0, 1'b1, 7, 1'b1, 1'b0);  step();
    drive_write(1'b0, 1'b1, 12, 1'b1, 1'b1); step();
    drive_write(1'b0, 1'b0, 0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      run_fetch(vecs[i].cl, 1'b0, 0, -1, 1'b0, 1'b0, 0, 1'b0, 1'b0, gu, gv);
      check_output($sformatf("vec%0d_unassign", i), gu, vecs[i].exp_unassign);
      check_output($sformatf("vec%0d_val", i), gv, vecs[i].exp_val);
    end

    // Backpressure with stray requests and writes to the clause's own variables.
    run_fetch(4, 1'b0, 5, -1, 1'b0, 1'b0, 0, 1'b0, 1'b0, gu, gv);
    check_output("stall_fetch_unassign", gu, 5'b00100);
    check_output("stall_fetch_val", gv, 5'b00001);

    // Re-establish vars 3,7 as assigned 1,0 and var 9 unassigned.
    drive_write(1'b0, 1'b1, 3, 1'b1, 1'b1); step();
    drive_write(1'b0, 1'b1, 7, 1'b1, 1'b0); step();
    drive_write(1'b0, 1'b1, 9, 1'b0, 1'b0); step();
    drive_write(1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Write var 9 in the cycle slot 2 is gathered (accept cycle + 4).
    run_fetch(4, 1'b0, 0, 4, 1'b0, 1'b1, 9, 1'b1, 1'b1, gu, gv);
`ifdef GATHER_WRITE_BYPASS_EN
    e_u = 5'b00000; e_v = 5'b00101;
`else
    e_u = 5'b00100; e_v = 5'b00001;
`endif
    check_output("same_cycle_unassign", gu, e_u);
    check_output("same_cycle_val", gv, e_v);

    drive_write(1'b1, 1'b1, 3, 1'b1, 1'b1); step();
    drive_write(1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_fetch(4, 1'b0, 0, -1, 1'b0, 1'b0, 0, 1'b0, 1'b0, gu, gv);
    check_output("clear_prio_unassign", gu, 5'b00111);
    check_output("clear_prio_val", gv, 5'b00000);

    for (int n = 0; n < 40; n++)
      run_fetch($urandom_range(0, NC-1), 1'b1, $urandom_range(0, 3), -1,
                1'b0, 1'b0, 0, 1'b0, 1'b0, gu, gv);

    // Abandon a fetch mid-gather with reset; table comes back all unassigned.
    drive_write(1'b0, 1'b0, 0, 1'b0, 1'b0);
    req_valid = 1'b1; req_clause = 5'd4;
    step();
    req_valid = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < NV; i++) m_asg[i] = 1'b0;
    check_output("midrst_req_ready", req_ready, 1);
    check_output("midrst_out_valid", out_valid, 0);
    check_output("midrst_unassign", unassign, 0);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check_output("post_rst_no_valid", out_valid, 0);
    end
    run_fetch(0, 1'b0, 0, -1, 1'b0, 1'b0, 0, 1'b0, 1'b0, gu, gv);
    check_output("post_rst_unassign", gu, 5'b00000);
    check_output("post_rst_val", gv, 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clause_operand_fetcher.md
CLAUSE_OPERAND_FETCHER -- requirements
Module: clause_operand_fetcher

Interface
REQ-001 Parameters SHALL be: VAR_PER_CLAUSE, default 5, literal slots per clause; NUM_VARS, default 64, assignment table depth; NUM_CLAUSES, default 32, clause memory depth; VAR_IDX_W = $clog2(NUM_VARS); CL_IDX_W = $clog2(NUM_CLAUSES).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low. Ports SHALL be: clock input 1 (rising-edge clock); reset_n input 1 (async active-low reset).
REQ-003 Request port SHALL be: req_valid input 1 (clause fetch request); req_clause input CL_IDX_W (clause index); req_ready output 1 (block idle, accepts request).
REQ-004 Clause memory port SHALL be: clause_rd_en output 1 (read strobe); clause_rd_addr output CL_IDX_W (read address); clause_rd_data input VAR_PER_CLAUSE*VAR_IDX_W+2*VAR_PER_CLAUSE (data valid the cycle after clause_rd_en; fields {var ids, pole, mask}, slot i var id at bits [i*VAR_IDX_W +: VAR_IDX_W]).
REQ-005 Assignment write port SHALL be: asgn_wr_en input 1 (write strobe); asgn_wr_var input VAR_IDX_W (variable); asgn_wr_assigned input 1 (1 = assigned, 0 = unassign); asgn_wr_val input 1 (value); asgn_clear input 1 (mark all variables unassigned).
REQ-006 Evaluator-facing output SHALL be: out_valid output 1; out_ready input 1; out_clause output CL_IDX_W; unassign, clause_mask, val, clause_pole each output VAR_PER_CLAUSE, bit i = slot i, ready to drive partial_sat_evaluator directly.

Function
REQ-007 Internal assignment table SHALL hold, per variable, assigned and value bits, read one entry per cycle (single read port).
REQ-008 FSM states SHALL be IDLE, MEM_WAIT, GATHER, PRESENT; req_ready=1 only in IDLE.
REQ-009 IDLE: on req_valid, the block SHALL latch req_clause, pulse clause_rd_en with clause_rd_addr=req_clause, and enter MEM_WAIT.
REQ-010 MEM_WAIT: the block SHALL capture clause_rd_data, load clause_mask and clause_pole, clear the slot counter, and enter GATHER.
REQ-011 GATHER: one slot per cycle, slot 0 first; masked slot -> unassign=0, val=0, no meaningful read; unmasked slot -> unassign=~assigned, val=assigned?value:0.
REQ-012 After slot VAR_PER_CLAUSE-1 the block SHALL enter PRESENT with out_valid=1; latency from request accept to out_valid SHALL be VAR_PER_CLAUSE+2 cycles.
REQ-013 PRESENT: outputs SHALL hold stable until out_valid&&out_ready, then return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-014 Table writes SHALL be accepted in every state; asgn_clear SHALL take priority over asgn_wr_en in the same cycle.
REQ-015 Outputs SHALL be a snapshot: writes to a slot's variable after that slot was gathered SHALL NOT alter presented outputs.
REQ-016 A duplicate variable id across slots SHALL be gathered independently per slot.
REQ-017 req_valid outside IDLE SHALL be ignored (no state change).

Reset
REQ-018 reset_n low SHALL asynchronously force IDLE, all table entries unassigned, req_ready=1 on release, and clause_rd_en, out_valid, out_clause, unassign, clause_mask, val, clause_pole all 0.
REQ-019 Reset mid-GATHER or mid-PRESENT SHALL abandon the fetch with no output handshake.

Configuration
REQ-020 Macro GATHER_WRITE_BYPASS_EN: defined -> a table write (or clear) to the variable being gathered in the same cycle SHALL be forwarded into that slot's gathered bits; undefined -> that slot SHALL capture the pre-write table value.

Verification
REQ-021 Reset then idle: req_ready=1, out_valid=0, all vector outputs 0.
REQ-022 Vars 3,7 assigned 1,0; clause 4 = ids {3,7,9,0,0}, mask 00111, pole 00011 -> out_valid at cycle 7 after accept, clause_mask=00111, unassign=00100, val=00001, clause_pole=00011, out_clause=4.
REQ-023 Same fetch with out_ready=0 for 5 cycles -> outputs stable, req_valid ignored, handshake completes on first out_ready=1 cycle, then req_ready=1.
REQ-024 Write var 9 assigned=1 val=1 in the cycle slot 2 is gathered -> with GATHER_WRITE_BYPASS_EN unassign[2]=0, val[2]=1; without, unassign[2]=1, val[2]=0.
REQ-025 asgn_clear and asgn_wr_en (var 3 assigned) in the same cycle, then fetch clause 4 -> unassign=00111.
REQ-026 reset_n low during GATHER -> immediate IDLE, no out_valid; subsequent fetch of clause with mask 00000 -> all vectors 0 at cycle 7.
